// File: rtl/clock509_revo_generator.sv
// Revolution marker generator: divides the 509 MHz RF clock to a word clock,
// counts revolutions and serializes the marker and a clock replica at DDR rate.

module clock509_serializer (
  input  logic       clock509,
  input  logic       word_clock,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] word,
  output logic       serial,
  output logic       locked
);
  logic [1:0] lock_sr = 2'b00;
  logic [7:0] sreg    = 8'h00;
  logic       rise    = 1'b0;
  logic       fall    = 1'b0;

  always_ff @(posedge word_clock) begin
    if (rst) lock_sr <= 2'b00;
    else     lock_sr <= {lock_sr[0], 1'b1};
  end

  assign locked = lock_sr[1];

  // load fires on the RF edge that raises word_clock, so word is sampled
  // before that word edge updates it; bits go out MSB-first, two per RF cycle
  always_ff @(posedge clock509) begin
    if (load) begin
      rise <= locked & word[7];
      fall <= locked & word[6];
      sreg <= locked ? {word[5:0], 2'b00} : 8'h00;
    end else begin
      rise <= sreg[7];
      fall <= sreg[6];
      sreg <= {sreg[5:0], 2'b00};
    end
  end

  assign serial = clock509 ? rise : fall;
endmodule

module clock509_revo_generator #(
  parameter int QUAD_BUNCHES       = 1280,
  parameter int RESET_STRETCH_LOG2 = 10
) (
  input  logic clock50,
  input  logic reset,
  input  logic local_clock509_in_p,
  input  logic local_clock509_in_n,
  output logic clk78_p,
  output logic clk78_n,
  output logic trg36_p,
  output logic trg36_n,
  output logic clk_se,
  output logic trg_se,
  output logic lemo,
  output logic led_0,
  output logic led_1,
  output logic led_2,
  output logic led_3,
  output logic led_4,
  output logic led_5,
  output logic led_6,
  output logic led_7
);
  localparam logic [10:0] RELOAD = 11'(QUAD_BUNCHES - 1);

  logic       clock509;
  logic       word_clock;
  logic [1:0] div_cnt = 2'd0;

  // p & ~n stays glitch-free whichever leg of the pair switches first
  assign clock509   = local_clock509_in_p & ~local_clock509_in_n;
  assign word_clock = div_cnt[1];

  always_ff @(posedge clock509) div_cnt <= div_cnt + 2'd1;

  logic [RESET_STRETCH_LOG2:0] rst_cnt = '0;
  logic                        rst_int = 1'b1;

  always_ff @(posedge clock50) begin
    if (reset) begin
      rst_cnt <= '0;
      rst_int <= 1'b1;
    end else begin
      if (!rst_cnt[RESET_STRETCH_LOG2]) rst_cnt <= rst_cnt + 1'b1;
      if (rst_cnt[RESET_STRETCH_LOG2])  rst_int <= 1'b0;
    end
  end

  logic [1:0] rst_sync = 2'b11;
  logic       rst_w;

  always_ff @(posedge word_clock) rst_sync <= {rst_sync[0], rst_int};
  assign rst_w = rst_sync[1];

  logic [10:0] qcnt      = RELOAD;
  logic        revo_flag = 1'b0;
  logic [7:0]  revo_word = 8'h00;

  always_ff @(posedge word_clock) begin
    if (rst_w) begin
      qcnt      <= RELOAD;
      revo_flag <= 1'b0;
      revo_word <= 8'h00;
    end else if (qcnt != 11'd0) begin
      qcnt      <= qcnt - 11'd1;
      revo_flag <= 1'b0;
      revo_word <= 8'h00;
    end else begin
      qcnt      <= RELOAD;
      revo_flag <= 1'b1;
      revo_word <= 8'hFF;
    end
  end

  logic load;
  logic revo_serial, revo_locked;
  logic clk_serial, clk_locked;

  assign load = (div_cnt == 2'd1);

  clock509_serializer u_revo_ser (
    .clock509(clock509), .word_clock(word_clock), .rst(rst_w), .load(load),
    .word(revo_word), .serial(revo_serial), .locked(revo_locked)
  );

  clock509_serializer u_clk_ser (
    .clock509(clock509), .word_clock(word_clock), .rst(rst_w), .load(load),
    .word(8'b1010_1010), .serial(clk_serial), .locked(clk_locked)
  );

  assign clk78_p = revo_flag;
  assign clk78_n = ~revo_flag;
  assign trg36_p = revo_serial;
  assign trg36_n = ~revo_serial;
  assign clk_se  = revo_flag;
  assign trg_se  = revo_flag;
  assign lemo    = clk_serial;

  assign led_7 = ~rst_w;
  assign led_6 = clk_locked;
  assign led_5 = revo_locked;
  assign led_4 = rst_int;
  assign led_3 = revo_flag;
  assign led_2 = 1'b0;
  assign led_1 = 1'b0;
  assign led_0 = 1'b0;
endmodule

// File: tb/tb_clock509_revo_generator.sv
// Bench for clock509_revo_generator: default instance plus a QUAD_BUNCHES=4 instance.
`timescale 1ns/100ps

module tb_clock509_revo_generator;
  logic clock50 = 1'b0;
  logic clk_p = 1'b0, clk_n = 1'b1;
  logic reset = 1'b1, reset4 = 1'b1;
  logic sel = 1'b0;

  logic a_clk78_p, a_clk78_n, a_trg36_p, a_trg36_n, a_clk_se, a_trg_se, a_lemo;
  logic [7:0] a_led;
  logic b_clk78_p, b_clk78_n, b_trg36_p, b_trg36_n, b_clk_se, b_trg_se, b_lemo;
  logic [7:0] b_led;

  clock509_revo_generator dut (
    .clock50(clock50), .reset(reset),
    .local_clock509_in_p(clk_p), .local_clock509_in_n(clk_n),
    .clk78_p(a_clk78_p), .clk78_n(a_clk78_n), .trg36_p(a_trg36_p), .trg36_n(a_trg36_n),
    .clk_se(a_clk_se), .trg_se(a_trg_se), .lemo(a_lemo),
    .led_0(a_led[0]), .led_1(a_led[1]), .led_2(a_led[2]), .led_3(a_led[3]),
    .led_4(a_led[4]), .led_5(a_led[5]), .led_6(a_led[6]), .led_7(a_led[7])
  );

  clock509_revo_generator #(.QUAD_BUNCHES(4), .RESET_STRETCH_LOG2(3)) dut4 (
    .clock50(clock50), .reset(reset4),
    .local_clock509_in_p(clk_p), .local_clock509_in_n(clk_n),
    .clk78_p(b_clk78_p), .clk78_n(b_clk78_n), .trg36_p(b_trg36_p), .trg36_n(b_trg36_n),
    .clk_se(b_clk_se), .trg_se(b_trg_se), .lemo(b_lemo),
    .led_0(b_led[0]), .led_1(b_led[1]), .led_2(b_led[2]), .led_3(b_led[3]),
    .led_4(b_led[4]), .led_5(b_led[5]), .led_6(b_led[6]), .led_7(b_led[7])
  );

  always #10 clock50 = ~clock50;
  always #1 begin clk_p = ~clk_p; clk_n = ~clk_p; end

  logic s_clk78_p, s_clk78_n, s_trg36_p, s_trg36_n, s_clk_se, s_trg_se, s_lemo;
  logic [7:0] s_led;
  assign s_clk78_p = sel ? b_clk78_p : a_clk78_p;
  assign s_clk78_n = sel ? b_clk78_n : a_clk78_n;
  assign s_trg36_p = sel ? b_trg36_p : a_trg36_p;
  assign s_trg36_n = sel ? b_trg36_n : a_trg36_n;
  assign s_clk_se  = sel ? b_clk_se  : a_clk_se;
  assign s_trg_se  = sel ? b_trg_se  : a_trg_se;
  assign s_lemo    = sel ? b_lemo    : a_lemo;
  assign s_led     = sel ? b_led     : a_led;

  int n_checks = 0;
  int n_fail   = 0;
  int k        = 0;   // word clocks since the edge that released rst_w
  int last_k   = 0;   // k of the last observed marker

  // reference: marker on every qb-th word clock after release; the serial copy
  // lags by one word; the replica runs once locked (2 words) was seen at load
  function automatic bit exp_flag(input int kk, input int qb);
    return (kk > 0) && (kk % qb == 0);
  endfunction

  task automatic wait_wedge();
    if (sel) @(posedge dut4.word_clock);
    else     @(posedge dut.word_clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clock50);
    n_checks++;
    if (a_led[4] !== 1'b1 || a_led[7] !== 1'b0 || a_led[6] !== 1'b0 || a_led[5] !== 1'b0 ||
        a_led[2:0] !== 3'b000) begin
      n_fail++; $display("FAIL reset_leds: got %b want 0001_0000", a_led);
    end
    n_checks++;
    if (a_clk78_p !== 1'b0 || a_clk78_n !== 1'b1 || a_trg36_p !== 1'b0 || a_trg36_n !== 1'b1 ||
        a_clk_se !== 1'b0 || a_trg_se !== 1'b0 || a_lemo !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: clk78=%b/%b trg36=%b/%b se=%b%b lemo=%b want 0/1 0/1 00 0",
               a_clk78_p, a_clk78_n, a_trg36_p, a_trg36_n, a_clk_se, a_trg_se, a_lemo);
    end
  endtask

  task automatic test_stretch();
    int n = 0;
    reset = 1'b0;
    while (n < 1500) begin
      @(posedge clock50); n++; #1;
      if (a_led[4] === 1'b0) break;
    end
    n_checks++;
    if (n != (2 ** 10) + 1) begin
      n_fail++; $display("FAIL stretch_len: led_4 fell after %0d cycles, want %0d", n, (2 ** 10) + 1);
    end
  endtask

  task automatic wait_run();
    int n = 0;
    bit seen = 0;
    while (n < 3000 && !seen) begin
      wait_wedge(); n++; #0.5;
      seen = (s_led[7] === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL run_timeout: led_7=%b after %0d word clocks, want 1", s_led[7], n);
    end
    k = 0;
    last_k = 0;
  endtask

  task automatic run_words(input int nwords, input int qb);
    bit ef, prev, lon;
    for (int w = 0; w < nwords; w++) begin
      wait_wedge(); k++; #0.5;
      ef   = exp_flag(k, qb);
      prev = exp_flag(k - 1, qb);
      lon  = (k >= 3);
      n_checks++;
      if (s_clk_se !== ef || s_trg_se !== ef || s_clk78_p !== ef || s_clk78_n !== !ef || s_led[3] !== ef) begin
        n_fail++;
        $display("FAIL revo_flag k=%0d: clk_se=%b trg_se=%b clk78=%b/%b led_3=%b want flag %b",
                 k, s_clk_se, s_trg_se, s_clk78_p, s_clk78_n, s_led[3], ef);
      end
      n_checks++;
      if (s_led[7] !== 1'b1 || s_led[4] !== 1'b0 || s_led[6] !== (k >= 2) || s_led[5] !== (k >= 2)) begin
        n_fail++;
        $display("FAIL status k=%0d: led=%b want led_7=1 led_4=0 locked=%b", k, s_led, k >= 2);
      end
      if (s_clk_se === 1'b1) begin
        if (last_k > 0) begin
          n_checks++;
          if (k - last_k != qb) begin
            n_fail++; $display("FAIL revo_period: got %0d word clocks want %0d", k - last_k, qb);
          end
        end
        last_k = k;
      end
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin @(posedge clk_p); #0.5; end
        n_checks++;
        if (s_trg36_p !== prev || s_trg36_n !== !prev || s_lemo !== lon) begin
          n_fail++;
          $display("FAIL serial_rise k=%0d i=%0d: trg36=%b/%b lemo=%b want trg %b lemo %b",
                   k, i, s_trg36_p, s_trg36_n, s_lemo, prev, lon);
        end
        @(negedge clk_p); #0.5;
        n_checks++;
        if (s_trg36_p !== prev || s_lemo !== 1'b0) begin
          n_fail++;
          $display("FAIL serial_fall k=%0d i=%0d: trg36=%b lemo=%b want trg %b lemo 0",
                   k, i, s_trg36_p, s_lemo, prev);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int hold;
    run_words(600, 1280);
    @(negedge clock50);
    reset = 1'b1;
    hold = $urandom_range(3, 8);
    for (int w = 0; w < 40; w++) begin
      wait_wedge(); #0.5;
      if (w == hold) reset = 1'b1;
      n_checks++;
      if (a_clk_se !== 1'b0 || a_trg36_p !== 1'b0) begin
        n_fail++; $display("FAIL mid_reset_quiet w=%0d: clk_se=%b trg36=%b want 0 0", w, a_clk_se, a_trg36_p);
      end
    end
    n_checks++;
    if (a_led[7] !== 1'b0 || a_led[6] !== 1'b0 || a_led[5] !== 1'b0 || a_led[4] !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_leds: got %b want led_7=0 led_6=0 led_5=0 led_4=1", a_led);
    end
    @(negedge clock50);
    test_stretch();
    wait_run();
    run_words(1280 + $urandom_range(5, 20), 1280);
  endtask

  task automatic test_quad4();
    sel = 1'b1;
    reset4 = 1'b1;
    repeat (5) @(negedge clock50);
    n_checks++;
    if (b_led[4] !== 1'b1 || b_led[6] !== 1'b0 || b_clk78_n !== 1'b1) begin
      n_fail++; $display("FAIL quad4_reset: led=%b clk78_n=%b want led_4=1 led_6=0 clk78_n=1", b_led, b_clk78_n);
    end
    reset4 = 1'b0;
    wait_run();
    run_words(32 + $urandom_range(0, 8), 4);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stretch();
    wait_run();
    run_words(3 * 1280 + $urandom_range(1, 40), 1280);
    test_reset_mid();
    test_quad4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
